// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer for the RV64 subset core.
// Steps FETCH/DECODE/EXEC/MEM/WB with memory handshakes, retire count and traps.
module core_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_en,
    input  logic                 step_req,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 pc_load,
    output logic                 pc_branch,
    output logic                 rf_we,
    output logic                 dmem_req,
    output logic                 dmem_re,
    output logic                 dmem_we,
    output logic                 halted,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        C_ALU = 2'd0,
        C_LD  = 2'd1,
        C_ST  = 2'd2,
        C_BR  = 2'd3
    } cls_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    // wait_cnt only has to reach TIMEOUT_CYCLES-1, the last accepting cycle
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST =
        WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          st_q;
    state_t          st_d;
    state_t          retire_to;
    cls_t            cls_q;
    cls_t            dec_cls;
    logic            dec_ok;
    logic            dec_sys;
    logic            step_mode;
    logic [WW-1:0]   wait_cnt;
    logic            waiting;
    logic            ack_now;
    logic            expire;
    logic            retire;
    logic [1:0]      err_d;

    assign state     = st_q;
    assign waiting   = (st_q == S_FETCH) || (st_q == S_MEM);
    assign ack_now   = (st_q == S_FETCH) ? imem_ack : dmem_ack;
    assign expire    = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);
    assign retire_to = (run_en && !step_mode) ? S_FETCH : S_IDLE;

    assign retire = ((st_q == S_EXEC) && (cls_q == C_BR))
                 || ((st_q == S_MEM) && (cls_q == C_ST) && dmem_ack)
                 || (st_q == S_WB);

    always_comb begin
        dec_cls = C_ALU;
        dec_ok  = 1'b1;
        dec_sys = 1'b0;
        unique case (opcode)
            OP_R, OP_I: dec_cls = C_ALU;
            OP_LD:      dec_cls = C_LD;
            OP_ST:      dec_cls = C_ST;
            OP_BR:      dec_cls = C_BR;
            OP_SYS:     dec_sys = 1'b1;
            default:    dec_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= S_IDLE;
            cls_q     <= C_ALU;
            step_mode <= 1'b0;
            wait_cnt  <= '0;
            instret   <= '0;
            err_code  <= 2'b00;
        end else begin
            st_q <= st_d;
            if (st_q == S_DECODE)
                cls_q <= dec_cls;
            if (retire)
                instret <= instret + INSTRET_W'(1);
            if (waiting && !ack_now && (TIMEOUT_CYCLES != 0))
                wait_cnt <= wait_cnt + WW'(1);
            else
                wait_cnt <= '0;
            if (st_q == S_IDLE)
                step_mode <= !run_en && step_req;
            else if (retire && (st_d == S_IDLE))
                step_mode <= 1'b0;
            if ((st_d == S_ERR) && (st_q != S_ERR))
                err_code <= err_d;
        end
    end

    // an ack in the expiry cycle takes priority over the timeout
    always_comb begin
        st_d  = st_q;
        err_d = 2'b00;
        unique case (st_q)
            S_IDLE: begin
                if (run_en || step_req)
                    st_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    st_d = S_DECODE;
                end else if (expire) begin
                    st_d  = S_ERR;
                    err_d = 2'b01;
                end
            end
            S_DECODE: begin
                if (dec_sys) begin
                    st_d = S_HALT;
                end else if (!dec_ok) begin
                    st_d  = S_ERR;
                    err_d = 2'b11;
                end else begin
                    st_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (cls_q)
                    C_BR:       st_d = retire_to;
                    C_LD, C_ST: st_d = S_MEM;
                    default:    st_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    st_d = (cls_q == C_ST) ? retire_to : S_WB;
                end else if (expire) begin
                    st_d  = S_ERR;
                    err_d = 2'b10;
                end
            end
            S_WB:    st_d = retire_to;
            default: st_d = st_q;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        pc_branch = 1'b0;
        rf_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        halted    = 1'b0;
        error     = 1'b0;
        unique case (st_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_EXEC: begin
                if (cls_q == C_BR) begin
                    pc_load   = 1'b1;
                    pc_branch = branch_taken;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_re  = (cls_q == C_LD);
                dmem_we  = (cls_q == C_ST);
                pc_load  = (cls_q == C_ST) && dmem_ack;
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_load = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_ERR:   error  = 1'b1;
            default: ;
        endcase
    end

endmodule
